// File: rtl/uart_puf.sv
// uart_puf: 8N1 UART sending '0'+tx_bit on request and keeping a 64-bit history of received bytes.
module uart_puf #(
  parameter int CLKS_PER_SAMPLE = 651
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  input  logic        transmit,
  input  logic [1:0]  tx_bit,
  output logic        received,
  output logic [63:0] rx_byte,
  output logic        is_receiving,
  output logic        is_transmitting,
  output logic        recv_error,
  output logic [3:0]  rx_samples,
  output logic [3:0]  rx_sample_countdown
);
  localparam int PW = $clog2(CLKS_PER_SAMPLE + 1);
  localparam logic [PW-1:0] PMAX = PW'(CLKS_PER_SAMPLE - 1);
  typedef enum logic [2:0] {IDLE, CHECK_START, READ_BITS, CHECK_STOP, ERROR_WAIT} rx_state_t;
  rx_state_t   rx_st_q, rx_st_d;
  logic        rx_m_q, rx_s_q;
  logic [PW-1:0] rx_pre_q, rx_pre_d, tx_pre_q, tx_pre_d;
  logic [3:0]  cd_q, cd_d, ones_q, ones_d, cnt_q, cnt_d;
  logic [2:0]  nbit_q, nbit_d;
  logic [7:0]  data_q, data_d;
  logic [63:0] hist_q, hist_d;
  logic        received_q, received_d, err_q, err_d;
  logic        busy_q, busy_d;
  logic [3:0]  tcnt_q, tcnt_d, idx_q, idx_d;
  logic [9:0]  sh_q, sh_d;
  logic        rx_tick, tx_tick, fire;
  assign rx_tick = rx_pre_q == PMAX;
  assign tx_tick = tx_pre_q == PMAX;
  assign fire    = rx_tick && cd_q == 4'd0;
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_pre_d   = rx_tick ? '0 : rx_pre_q + 1'b1;
    cd_d       = (rx_tick && cd_q != 4'd0) ? cd_q - 4'd1 : cd_q;
    ones_d     = ones_q;
    cnt_d      = cnt_q;
    nbit_d     = nbit_q;
    data_d     = data_q;
    hist_d     = hist_q;
    received_d = 1'b0;
    err_d      = 1'b0;
    case (rx_st_q)
      IDLE: if (!rx_s_q) begin
        rx_st_d  = CHECK_START;
        cd_d     = 4'd7;
        rx_pre_d = '0;
      end
      CHECK_START: if (fire) begin
        rx_st_d = rx_s_q ? IDLE : READ_BITS;
        cd_d    = rx_s_q ? 4'd0 : 4'd15;
        nbit_d  = 3'd0;
      end
      READ_BITS: if (fire) begin
        data_d  = {rx_s_q, data_q[7:1]};
        cd_d    = 4'd15;
        nbit_d  = nbit_q + 3'd1;
        rx_st_d = (nbit_q == 3'd7) ? CHECK_STOP : READ_BITS;
      end
      CHECK_STOP: if (fire) begin
        received_d = rx_s_q;
        err_d      = !rx_s_q;
        hist_d     = rx_s_q ? {hist_q[55:0], data_q} : hist_q;
        cnt_d      = rx_s_q ? cnt_q + 4'd1 : cnt_q;
        ones_d     = 4'd0;
        rx_st_d    = rx_s_q ? IDLE : ERROR_WAIT;
      end
      ERROR_WAIT: if (rx_tick) begin
        // need 16 consecutive high ticks before the line counts as idle again
        ones_d  = rx_s_q ? ones_q + 4'd1 : 4'd0;
        rx_st_d = (rx_s_q && ones_q == 4'd15) ? IDLE : ERROR_WAIT;
      end
      default: rx_st_d = IDLE;
    endcase
  end
  always_comb begin
    busy_d   = busy_q;
    tx_pre_d = tx_tick ? '0 : tx_pre_q + 1'b1;
    tcnt_d   = tcnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    if (!busy_q) begin
      if (transmit) begin
        busy_d   = 1'b1;
        tx_pre_d = '0;
        tcnt_d   = 4'd0;
        idx_d    = 4'd0;
        sh_d     = {1'b1, 8'h30 + {6'd0, tx_bit}, 1'b0};
      end
    end else if (tx_tick) begin
      tcnt_d = tcnt_q + 4'd1;
      if (tcnt_q == 4'd15) begin
        sh_d   = {1'b1, sh_q[9:1]};
        idx_d  = idx_q + 4'd1;
        busy_d = idx_q != 4'd9;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m_q     <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_st_q    <= IDLE;
      rx_pre_q   <= '0;
      cd_q       <= 4'd0;
      ones_q     <= 4'd0;
      cnt_q      <= 4'd0;
      nbit_q     <= 3'd0;
      data_q     <= 8'd0;
      hist_q     <= 64'd0;
      received_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      tx_pre_q   <= '0;
      tcnt_q     <= 4'd0;
      idx_q      <= 4'd0;
      sh_q       <= '1;
    end else begin
      rx_m_q     <= rx;
      rx_s_q     <= rx_m_q;
      rx_st_q    <= rx_st_d;
      rx_pre_q   <= rx_pre_d;
      cd_q       <= cd_d;
      ones_q     <= ones_d;
      cnt_q      <= cnt_d;
      nbit_q     <= nbit_d;
      data_q     <= data_d;
      hist_q     <= hist_d;
      received_q <= received_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      tx_pre_q   <= tx_pre_d;
      tcnt_q     <= tcnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
    end
  end
  assign tx                  = sh_q[0];
  assign received            = received_q;
  assign recv_error          = err_q;
  assign rx_byte             = hist_q;
  assign rx_samples          = cnt_q;
  assign rx_sample_countdown = cd_q;
  assign is_receiving        = rx_st_q != IDLE;
  assign is_transmitting     = busy_q;
endmodule

// File: tb/tb_uart_puf.sv
// tb_uart_puf: directed checks of uart_puf with 2 clks per oversample tick (32-clk bit).
module tb_uart_puf;
  logic        clk = 1'b0, rst = 1'b1, rx = 1'b1, transmit = 1'b0;
  logic [1:0]  tx_bit = 2'd0;
  logic        tx, received, is_receiving, is_transmitting, recv_error;
  logic [63:0] rx_byte;
  logic [3:0]  rx_samples, rx_sample_countdown;
  int n_cmp = 0, n_bad = 0, rcv_n = 0, err_n = 0, rcv_b, err_b;
  uart_puf #(.CLKS_PER_SAMPLE(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .transmit(transmit), .tx_bit(tx_bit),
    .received(received), .rx_byte(rx_byte), .is_receiving(is_receiving),
    .is_transmitting(is_transmitting), .recv_error(recv_error),
    .rx_samples(rx_samples), .rx_sample_countdown(rx_sample_countdown)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (received) rcv_n++;
    if (recv_error) err_n++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    rx = 1'b1;
    transmit = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rcv_b = rcv_n;
    err_b = err_n;
    @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (32) @(negedge clk);
    end
    repeat (20) @(negedge clk);
  endtask
  initial begin
    logic [9:0] frame;
    logic [63:0] h;
    do_reset();
    check("rst_tx", tx, 1'b1);
    check("rst_rx_byte", rx_byte, 64'd0);
    check("rst_samples", rx_samples, 4'd0);
    check("rst_flags", {received, recv_error, is_receiving, is_transmitting}, 4'b0);
    check("rst_countdown", rx_sample_countdown, 4'd0);
    tx_bit = 2'd1;
    transmit = 1'b1;
    @(negedge clk);
    transmit = 1'b0;
    repeat (10) @(negedge clk);
    check("midtx_start", {tx, is_transmitting}, 2'b01);
    #2 rst = 1'b1;
    #1 check("midtx_rst", {tx, is_transmitting}, 2'b10);
    do_reset();
    frame = {1'b1, 8'h32, 1'b0};
    tx_bit = 2'b10;
    transmit = 1'b1;
    @(posedge clk);
    #1 transmit = 1'b0;
    for (int k = 0; k < 10; k++) begin
      repeat (16) @(posedge clk);
      #1 check($sformatf("tx_bit%0d", k), tx, frame[k]);
      if (k < 9) repeat (16) @(posedge clk);
    end
    repeat (15) @(posedge clk);
    #1 check("tx_busy_319", is_transmitting, 1'b1);
    @(posedge clk);
    #1 check("tx_done_320", {is_transmitting, tx}, 2'b01);
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h3C);
    check("rx2_byte", rx_byte, 64'h0000_0000_0000_A53C);
    check("rx2_samples", rx_samples, 4'd2);
    check("rx2_pulses", rcv_n - rcv_b, 2);
    check("rx2_errors", err_n - err_b, 0);
    do_reset();
    rx = 1'b0;
    repeat (400) @(negedge clk);
    check("ferr_pulse", err_n - err_b, 1);
    check("ferr_no_rcv", rcv_n - rcv_b, 0);
    check("ferr_busy", is_receiving, 1'b1);
    repeat (400) @(negedge clk);
    check("ferr_held", {32'(err_n - err_b), 31'd0, is_receiving}, {32'd1, 31'd0, 1'b1});
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_wait", is_receiving, 1'b1);
    repeat (40) @(negedge clk);
    check("ferr_idle", is_receiving, 1'b0);
    check("ferr_byte", {rx_byte, rx_samples}, 68'd0);
    do_reset();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_seen", is_receiving, 1'b1);
    repeat (50) @(negedge clk);
    check("glitch_idle", is_receiving, 1'b0);
    check("glitch_pulses", (rcv_n - rcv_b) + (err_n - err_b), 0);
    do_reset();
    h = 64'd0;
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i));
      h = {h[55:0], 8'(i)};
    end
    check("rx9_byte", rx_byte, 64'h0203_0405_0607_0809);
    check("rx9_model", rx_byte, h);
    check("rx9_samples", rx_samples, 4'd9);
    check("rx9_pulses", rcv_n - rcv_b, 9);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
